decode_cycle: RTL and testbench

DECODE_CYCLE -- requirements
Module: decode_cycle

---
 rtl/decode_cycle.sv | 212 +++++++++++++++++++++
 tb/tb_decode_cycle.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// Decode stage of a single-issue RISC-V pipeline: register file, control decode and the ID/EX register.
// Defining DECODE_WB_BYPASS_EN forwards a same-cycle writeback into the register reads.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrd,
  input  logic [31:0] pcd,
  input  logic [31:0] pcplus4d,
  input  logic        flushe,
  input  logic        regwritew,
  input  logic [4:0]  rdw,
  input  logic [31:0] resultw,
  output logic        regwritee,
  output logic        memwritee,
  output logic        jumpe,
  output logic        branche,
  output logic        alusrce,
  output logic [1:0]  resultsrce,
  output logic [2:0]  alucontrole,
  output logic [31:0] rd1e,
  output logic [31:0] rd2e,
  output logic [31:0] immexte,
  output logic [31:0] pce,
  output logic [31:0] pcplus4e,
  output logic [4:0]  rde,
  output logic [4:0]  rs1e,
  output logic [4:0]  rs2e
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_sel_e;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic       alusrc;
    logic [1:0] resultsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rd1, rd2, imm_ext;
  alu_op_e     funct_alu;
  imm_sel_e    imm_sel;
  ctrl_t       ctrl_d, ctrl_q;

  logic [31:0] rf_q [32];

  logic [31:0] rd1_q, rd2_q, imm_q, pc_q, pcplus4_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;

  assign opcode = instrd[6:0];
  assign funct3 = instrd[14:12];
  assign rd     = instrd[11:7];
  assign rs1    = instrd[19:15];
  assign rs2    = instrd[24:20];

  // NOTE: the register file is cleared by reset, so it must be flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (regwritew && rdw != 5'd0) begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      rf_q[rdw] <= resultw;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rd1 = (regwritew && rdw != 5'd0 && rdw == rs1) ? resultw : rf_q[rs1];
  assign rd2 = (regwritew && rdw != 5'd0 && rdw == rs2) ? resultw : rf_q[rs2];
`else
  assign rd1 = rf_q[rs1];
  assign rd2 = rf_q[rs2];
`endif

  // funct3 mapping shared by R-type and I-ALU; only R-type honours funct7[5] for sub.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (opcode == OP_RTYPE && instrd[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    ctrl_d  = '0;
    imm_sel = IMM_I;
    case (opcode)
      OP_LOAD: begin
        ctrl_d.regwrite  = 1'b1;
        ctrl_d.resultsrc = RES_MEM;
        ctrl_d.alusrc    = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.memwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        imm_sel         = IMM_S;
      end
      OP_RTYPE: begin
        ctrl_d.regwrite   = 1'b1;
        ctrl_d.alucontrol = funct_alu;
      end
      OP_IALU: begin
        ctrl_d.regwrite   = 1'b1;
        ctrl_d.alusrc     = 1'b1;
        ctrl_d.alucontrol = funct_alu;
      end
      OP_BRANCH: begin
        ctrl_d.branch     = 1'b1;
        ctrl_d.alucontrol = ALU_SUB;
        imm_sel           = IMM_B;
      end
      OP_JAL: begin
        ctrl_d.jump      = 1'b1;
        ctrl_d.regwrite  = 1'b1;
        ctrl_d.resultsrc = RES_PC4;
        imm_sel          = IMM_J;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (imm_sel)
      IMM_I: imm_ext = {{20{instrd[31]}}, instrd[31:20]};
      IMM_S: imm_ext = {{20{instrd[31]}}, instrd[31:25], instrd[11:7]};
      IMM_B: imm_ext = {{19{instrd[31]}}, instrd[31], instrd[7], instrd[30:25], instrd[11:8], 1'b0};
      IMM_J: imm_ext = {{11{instrd[31]}}, instrd[31], instrd[19:12], instrd[20], instrd[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // A flush kills controls and indices; data fields are captured regardless since they are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      pcplus4_q <= '0;
    end else begin
      if (flushe) begin
        ctrl_q <= '0;
        rd_q   <= '0;
        rs1_q  <= '0;
        rs2_q  <= '0;
      end else begin
        ctrl_q <= ctrl_d;
        rd_q   <= rd;
        rs1_q  <= rs1;
        rs2_q  <= rs2;
      end
      rd1_q     <= rd1;
      rd2_q     <= rd2;
      imm_q     <= imm_ext;
      pc_q      <= pcd;
      pcplus4_q <= pcplus4d;
    end
  end

  assign regwritee   = ctrl_q.regwrite;
  assign memwritee   = ctrl_q.memwrite;
  assign jumpe       = ctrl_q.jump;
  assign branche     = ctrl_q.branch;
  assign alusrce     = ctrl_q.alusrc;
  assign resultsrce  = ctrl_q.resultsrc;
  assign alucontrole = ctrl_q.alucontrol;
  assign rd1e        = rd1_q;
  assign rd2e        = rd2_q;
  assign immexte     = imm_q;
  assign pce         = pc_q;
  assign pcplus4e    = pcplus4_q;
  assign rde         = rd_q;
  assign rs1e        = rs1_q;
  assign rs2e        = rs2_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed testbench for decode_cycle: reset, decode of each opcode class, flush, x0 and writeback timing.
// Expected same-cycle read value follows DECODE_WB_BYPASS_EN.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrd, pcd, pcplus4d, resultw;
  logic        flushe, regwritew;
  logic [4:0]  rdw;
  logic        regwritee, memwritee, jumpe, branche, alusrce;
  logic [1:0]  resultsrce;
  logic [2:0]  alucontrole;
  logic [31:0] rd1e, rd2e, immexte, pce, pcplus4e;
  logic [4:0]  rde, rs1e, rs2e;
  logic [9:0]  ctrl_vec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .instrd(instrd), .pcd(pcd), .pcplus4d(pcplus4d),
    .flushe(flushe), .regwritew(regwritew), .rdw(rdw), .resultw(resultw),
    .regwritee(regwritee), .memwritee(memwritee), .jumpe(jumpe), .branche(branche),
    .alusrce(alusrce), .resultsrce(resultsrce), .alucontrole(alucontrole),
    .rd1e(rd1e), .rd2e(rd2e), .immexte(immexte), .pce(pce), .pcplus4e(pcplus4e),
    .rde(rde), .rs1e(rs1e), .rs2e(rs2e)
  );

  assign ctrl_vec = {regwritee, memwritee, jumpe, branche, alusrce, resultsrce, alucontrole};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    instrd   = instr;
    pcd      = pc;
    pcplus4d = pc + 32'd4;
    step();
  endtask

  localparam logic [31:0] ADDI_X6_X5_5 = 32'h00528313;
  localparam logic [31:0] BEQ_M4       = 32'hFE000EE3;
  localparam logic [31:0] JAL_X1_8     = 32'h008000EF;
  localparam logic [31:0] ADD_X8_X7_X5 = 32'h00538433;

  logic [31:0] same_cycle_exp;

  initial begin
    rst = 1'b1; instrd = '0; pcd = '0; pcplus4d = '0;
    flushe = 1'b0; regwritew = 1'b0; rdw = '0; resultw = '0;
    #2 rst = 1'b0;
    #1;
    check("async_reset_ctrl", 32'(ctrl_vec), 32'd0);

    // Random activity while held in reset must not disturb anything.
    for (int i = 0; i < 4; i++) begin
      instrd = $urandom; pcd = $urandom; pcplus4d = $urandom;
      flushe = 1'($urandom); regwritew = 1'b1; rdw = 5'd5; resultw = $urandom;
      step();
      check("rst_ctrl", 32'(ctrl_vec), 32'd0);
      check("rst_rd1e", rd1e, 32'd0);
      check("rst_imm", immexte, 32'd0);
      check("rst_pce", pce, 32'd0);
      check("rst_rde", 32'(rde), 32'd0);
    end
    rst = 1'b1; flushe = 1'b0; regwritew = 1'b0;

    issue(ADDI_X6_X5_5, 32'h40);
    check("post_rst_x5", rd1e, 32'd0);
    check("post_rst_regwrite", 32'(regwritee), 32'd1);

    // Write x5 = 7, then addi x6, x5, 5.
    regwritew = 1'b1; rdw = 5'd5; resultw = 32'd7;
    issue(32'h0, 32'h44);
    check("bubble_opcode0", 32'(ctrl_vec), 32'd0);
    regwritew = 1'b0;
    issue(ADDI_X6_X5_5, 32'h48);
    check("addi_rd1e", rd1e, 32'd7);
    check("addi_imm", immexte, 32'd5);
    check("addi_rde", 32'(rde), 32'd6);
    check("addi_rs1e", 32'(rs1e), 32'd5);
    check("addi_alusrc", 32'(alusrce), 32'd1);
    check("addi_regwrite", 32'(regwritee), 32'd1);
    check("addi_aluctl", 32'(alucontrole), 32'd0);
    check("addi_ressrc", 32'(resultsrce), 32'd0);
    check("addi_pcplus4", pcplus4e, 32'h4C);

    issue(BEQ_M4, 32'h100);
    check("beq_branch", 32'(branche), 32'd1);
    check("beq_aluctl", 32'(alucontrole), 32'd1);
    check("beq_imm", immexte, 32'hFFFFFFFC);
    check("beq_pce", pce, 32'h100);
    check("beq_alusrc", 32'(alusrce), 32'd0);
    check("beq_regwrite", 32'(regwritee), 32'd0);

    issue(JAL_X1_8, 32'h104);
    check("jal_jump", 32'(jumpe), 32'd1);
    check("jal_ressrc", 32'(resultsrce), 32'd2);
    check("jal_imm", immexte, 32'd8);
    check("jal_rde", 32'(rde), 32'd1);
    check("jal_regwrite", 32'(regwritee), 32'd1);

    // Flush the same jal while a writeback of x7 happens in the same cycle.
    flushe = 1'b1; regwritew = 1'b1; rdw = 5'd7; resultw = 32'h55;
    issue(JAL_X1_8, 32'h104);
    check("flush_ctrl", 32'(ctrl_vec), 32'd0);
    check("flush_rde", 32'(rde), 32'd0);
    check("flush_rs1e", 32'(rs1e), 32'd0);
    flushe = 1'b0; regwritew = 1'b0;

    issue(ADD_X8_X7_X5, 32'h108);
    check("flush_wb_x7", rd1e, 32'h55);
    check("add_rd2e", rd2e, 32'd7);
    check("add_aluctl", 32'(alucontrole), 32'd0);
    check("add_alusrc", 32'(alusrce), 32'd0);
    check("add_regwrite", 32'(regwritee), 32'd1);
    check("add_rs2e", 32'(rs2e), 32'd5);

    issue(32'h40538433, 32'h10C);
    check("sub_aluctl", 32'(alucontrole), 32'd1);
    issue(32'h0053A433, 32'h110);
    check("slt_aluctl", 32'(alucontrole), 32'd5);
    issue(32'h0053E433, 32'h114);
    check("or_aluctl", 32'(alucontrole), 32'd3);
    issue(32'h0053F433, 32'h118);
    check("and_aluctl", 32'(alucontrole), 32'd2);
    issue(32'h00539433, 32'h11C);
    check("r_unsup_f3_aluctl", 32'(alucontrole), 32'd0);
    check("r_unsup_f3_regwrite", 32'(regwritee), 32'd1);

    // addi with imm bit 30 set must still be add, not sub.
    issue(32'h40028313, 32'h120);
    check("addi_f7_aluctl", 32'(alucontrole), 32'd0);
    check("addi_f7_imm", immexte, 32'h400);

    issue(32'h0082A483, 32'h124);
    check("lw_ressrc", 32'(resultsrce), 32'd1);
    check("lw_alusrc", 32'(alusrce), 32'd1);
    check("lw_regwrite", 32'(regwritee), 32'd1);
    check("lw_imm", immexte, 32'd8);

    issue(32'hFE72AE23, 32'h128);
    check("sw_memwrite", 32'(memwritee), 32'd1);
    check("sw_regwrite", 32'(regwritee), 32'd0);
    check("sw_imm", immexte, 32'hFFFFFFFC);
    check("sw_rd2e", rd2e, 32'h55);

    // Same-cycle write of x5 = 0xA while reading x5.
`ifdef DECODE_WB_BYPASS_EN
    same_cycle_exp = 32'hA;
`else
    same_cycle_exp = 32'd7;
`endif
    regwritew = 1'b1; rdw = 5'd5; resultw = 32'hA;
    issue(ADDI_X6_X5_5, 32'h12C);
    check("same_cycle_rd1e", rd1e, same_cycle_exp);
    regwritew = 1'b0;
    issue(ADDI_X6_X5_5, 32'h130);
    check("after_write_rd1e", rd1e, 32'hA);

    // x0 write is ignored and never bypassed.
    regwritew = 1'b1; rdw = 5'd0; resultw = 32'hFFFFFFFF;
    issue(32'h00000313, 32'h134);
    check("x0_same_cycle", rd1e, 32'd0);
    regwritew = 1'b0;
    issue(32'h00000313, 32'h138);
    check("x0_read", rd1e, 32'd0);

    issue(32'hFFFFFFFF, 32'h200);
    check("unsup_ctrl", 32'(ctrl_vec), 32'd0);
    check("unsup_rs1e", 32'(rs1e), 32'd31);
    check("unsup_pce", pce, 32'h200);

    // Reset mid-cycle with a pending writeback of x5.
    regwritew = 1'b1; rdw = 5'd5; resultw = 32'h99;
    instrd = ADDI_X6_X5_5; pcd = 32'h300; pcplus4d = 32'h304;
    #3 rst = 1'b0;
    #1;
    check("mid_rst_rde", 32'(rde), 32'd0);
    check("mid_rst_pce", pce, 32'd0);
    check("mid_rst_rs1e", 32'(rs1e), 32'd0);
    step();
    rst = 1'b1; regwritew = 1'b0;
    issue(ADDI_X6_X5_5, 32'h300);
    check("mid_rst_x5_cleared", rd1e, 32'd0);
    check("mid_rst_first_capture", 32'(regwritee), 32'd1);
    check("mid_rst_first_imm", immexte, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
